rr_arbiter8: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters, producing a registered one-hot grant vector and its 3-bit index. It sequences the 3-to-8 one-hot decode path of the lab datapath: the arbiter owns the index and the one-hot select is derived from it. It sits between eight client blocks and a single shared resource (bus, display digit, memory port).

---
 rtl/arb_pkg.sv | 15 +
 rtl/onehot_dec3to8.sv | 15 +
 rtl/rr_arbiter8.sv | 142 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Pointer value after reset: the first search then starts at requester 0.
    localparam logic [IDX_W-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder; purely combinational.
module onehot_dec3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Set exactly the bit selected by the index.
    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with registered one-hot grant.
// Optional forced release after TIMEOUT_CYCLES grant cycles is built only
// when the ARB_TIMEOUT_EN macro is defined; otherwise timeout is tied low.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout
);

    arb_state_t          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic [IDX_W-1:0]    last_q;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                hold_req;
    logic                expire;
    logic                release_ev;
    logic                load;

    // Rotating-priority search starting just after the last granted index.
    // Offsets are scanned from farthest to nearest so the nearest set bit
    // is the one left standing; offset NUM_REQ lands on last_q itself,
    // which gives the previous holder lowest priority.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last_q + IDX_W'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    onehot_dec3to8 u_dec (
        .idx_i    (win_idx),
        .onehot_o (win_onehot)
    );

    assign hold_req = req[idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       timeout_q;
    logic       to_fire;

    assign expire  = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    // Only a release caused solely by expiry is reported as a timeout.
    assign to_fire = (state_q == ARB_GRANT) && expire && !done && hold_req;

    // Hold counter: cleared on every new grant, counts grant cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_fire;
            if (load)
                cnt_q <= '0;
            else if (state_q == ARB_GRANT)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // In GRANT last_q already equals idx_q, so the search above is the
    // post-release search as well.
    assign release_ev = done || !hold_req || expire;
    assign load       = win_found && ((state_q == ARB_IDLE) || release_ev);

    // Two-state FSM with registered grant, index, busy and pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (load) begin
                        state_q <= ARB_GRANT;
                        grant_q <= win_onehot;
                        idx_q   <= win_idx;
                        busy_q  <= 1'b1;
                        last_q  <= win_idx;
                    end
                end
                ARB_GRANT: begin
                    if (load) begin
                        grant_q <= win_onehot;
                        idx_q   <= win_idx;
                        last_q  <= win_idx;
                    end else if (release_ev) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = busy_q;

    // Grant must never have more than one bit set.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

    // Busy tracks a non-empty grant.
    a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy_q == (grant_q != '0));

    // Timeout length must stay inside the counter's range.
    a_param: assert property (@(posedge clk)
        (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 256));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 with a behavioural round-robin model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: holder index (-1 idle), round-robin pointer, hold count.
    int m_hold, m_last, m_cnt;
    bit m_to;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++)
            if (r[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        logic [2:0] ix;
        g  = (m_hold < 0) ? 8'h00 : 8'(1 << m_hold);
        ix = (m_hold < 0) ? 3'd0 : 3'(m_hold);
        return {g, ix, (m_hold >= 0), m_to};
    endfunction

    task automatic model_reset();
        m_hold = -1; m_last = 7; m_cnt = 0; m_to = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d);
        int  w;
        bit  ex, rel;
        m_to = 1'b0;
        if (m_hold < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin m_hold = w; m_last = w; m_cnt = 0; end
        end else begin
            ex  = TO_EN && (m_cnt == TO - 1);
            rel = d || !r[m_hold] || ex;
            if (rel) begin
                m_to   = ex && !d && r[m_hold];
                m_last = m_hold;
                w      = pick(r, m_last);
                if (w >= 0) begin m_hold = w; m_last = w; m_cnt = 0; end
                else m_hold = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Drive at the falling edge, let one rising edge happen, sample 1 later.
    task automatic step(input logic [7:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        #1;
        n_tests++;
        if ({grant, grant_idx, busy, timeout} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {grant, grant_idx, busy, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1; req = '0;
        model_reset();
    endtask

    task automatic test_first_grant();
        do_reset();
        step(8'h01, 1'b0);
        n_tests++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got g=%h i=%0d b=%b want g=01 i=0 b=1", grant, grant_idx, busy);
        end
        // Assert reset away from any clock edge while the grant is held.
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({grant, grant_idx, busy, timeout} !== 13'h0) begin
            n_fail++;
            $display("FAIL async_reset_mid_grant: got %h want 0", {grant, grant_idx, busy, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rotate();
        logic [7:0] want;
        do_reset();
        step(8'hFF, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF, 1'b1);
            want = 8'(1 << (i % 8));
            n_tests++;
            if (grant !== want || busy !== 1'b1 || {grant, grant_idx, busy, timeout} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotate[%0d]: got g=%h b=%b want g=%h b=1", i, grant, busy, want);
            end
        end
    endtask

    task automatic test_skip();
        int seq [3] = '{7, 0, 3};
        do_reset();
        step(8'h08, 1'b0);
        n_tests++;
        if (grant_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL skip_setup: got idx=%0d want 3", grant_idx);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h89, 1'b1);
            n_tests++;
            if (grant_idx !== 3'(seq[i]) || grant !== 8'(1 << seq[i])) begin
                n_fail++;
                $display("FAIL skip[%0d]: got idx=%0d g=%h want idx=%0d", i, grant_idx, grant, seq[i]);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        n_tests++;
        if (grant !== 8'h20 || grant_idx !== 3'd5) begin
            n_fail++;
            $display("FAIL withdraw_hold: got g=%h want 20", grant);
        end
        step(8'h00, 1'b0);
        n_tests++;
        if (grant !== 8'h00 || grant_idx !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_idle: got g=%h i=%0d b=%b want 00 0 0", grant, grant_idx, busy);
        end
    endtask

    task automatic test_regrant();
        do_reset();
        step(8'h04, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'h04, 1'b1);
            n_tests++;
            if (grant !== 8'h04 || busy !== 1'b1 || grant_idx !== 3'd2) begin
                n_fail++;
                $display("FAIL regrant[%0d]: got g=%h b=%b want 04 1", i, grant, busy);
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            step(8'h02, 1'b0);
            for (int i = 0; i < 3; i++) begin
                step(8'h06, 1'b0);
                n_tests++;
                if (grant !== 8'h02 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_hold[%0d.%0d]: got g=%h t=%b want 02 0", pass, i, grant, timeout);
                end
            end
            step(8'h06, pass == 1);
            n_tests++;
            if (grant !== 8'h04 || timeout !== (pass == 0)) begin
                n_fail++;
                $display("FAIL timeout_expire[%0d]: got g=%h t=%b want 04 %0d", pass, grant, timeout, pass == 0);
            end
            step(8'h06, 1'b0);
            n_tests++;
            if (timeout !== 1'b0 || grant !== 8'h04) begin
                n_fail++;
                $display("FAIL timeout_pulse_len[%0d]: got t=%b g=%h want 0 04", pass, timeout, grant);
            end
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        step(8'h02, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(8'h06, 1'b0);
            n_tests++;
            if (grant !== 8'h02 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever[%0d]: got g=%h t=%b want 02 0", i, grant, timeout);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] r;
        logic       d;
        do_reset();
        r = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            // Keep the request vector stable most of the time so grants last.
            if ($urandom_range(0, 3) == 0)
                r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
            n_tests++;
            if ({grant, grant_idx, busy, timeout} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%h done=%b got %h want %h", i, r, d,
                         {grant, grant_idx, busy, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_rotate();
        test_skip();
        test_withdraw();
        test_regrant();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
